// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transmitter and receiver.
package uart_pkg;

  localparam int NUM_BITS = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_if.sv
// Byte-side handshake between the pin wrapper and one UART direction.
// The master drives the byte, its strobe and an error flag; the slave reports busy.
interface uart_if;
  import uart_pkg::*;

  logic [NUM_BITS-1:0] data;
  logic                valid;
  logic                err;
  logic                busy;

  modport master (output data, output valid, output err, input busy);
  modport slave  (input data, input valid, input err, output busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver with a two-flop input synchronizer and centre-of-bit sampling.
// state    | meaning
// RX_IDLE  | waiting for a low line after having seen it high
// RX_START | half-bit wait, then confirm start bit (1 = glitch)
// RX_DATA  | sample 8 data bits at bit centres, LSB first
// RX_STOP  | sample stop bit; pulse valid or frame error
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   line,
  uart_if.master bus
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(NUM_BITS);
  localparam logic [TW-1:0] TICK_LOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(NUM_BITS - 1);

  rx_state_t           state;
  logic                sync1;
  logic                sync2;
  logic                armed;
  logic [TW-1:0]       tick;
  logic [BW-1:0]       bits_left;
  logic [NUM_BITS-1:0] shreg;
  logic [NUM_BITS-1:0] data_q;
  logic                valid_q;
  logic                err_q;

  wire unused_busy = bus.busy;

  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      state     <= RX_IDLE;
      armed     <= 1'b0;
      tick      <= '0;
      bits_left <= '0;
      shreg     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync1   <= line;
      sync2   <= sync1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        RX_IDLE: begin
          // A start is only accepted once the line has been seen high again.
          if (!sync2 && armed) begin
            tick  <= HALF_LOAD;
            state <= RX_START;
          end else if (sync2) begin
            armed <= 1'b1;
          end
        end
        RX_START: begin
          if (tick == '0) begin
            if (sync2) begin
              armed <= 1'b0;
              state <= RX_IDLE;
            end else begin
              tick      <= TICK_LOAD;
              bits_left <= LAST_BIT;
              state     <= RX_DATA;
            end
          end else begin
            tick <= tick - 1'b1;
          end
        end
        RX_DATA: begin
          if (tick == '0) begin
            shreg <= {sync2, shreg[NUM_BITS-1:1]};
            tick  <= TICK_LOAD;
            if (bits_left == '0) begin
              state <= RX_STOP;
            end else begin
              bits_left <= bits_left - 1'b1;
            end
          end else begin
            tick <= tick - 1'b1;
          end
        end
        RX_STOP: begin
          if (tick == '0) begin
            if (sync2) begin
              data_q  <= shreg;
              valid_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            armed <= 1'b0;
            state <= RX_IDLE;
          end else begin
            tick <= tick - 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: latches a byte on valid while idle and shifts it out LSB first.
// state    | meaning
// TX_IDLE  | line high, waiting for valid
// TX_START | start bit (0) on the line
// TX_DATA  | data bits, LSB first
// TX_STOP  | stop bit (1); busy drops when it completes
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic   clk,
  input  logic   rst,
  uart_if.slave  bus,
  output logic   line
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(NUM_BITS);
  localparam logic [TW-1:0] TICK_LOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(NUM_BITS - 1);

  tx_state_t           state;
  logic [TW-1:0]       tick;
  logic [BW-1:0]       bits_left;
  logic [NUM_BITS-1:0] shreg;
  logic                busy_q;

  wire unused_err = bus.err;

  assign bus.busy = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= TX_IDLE;
      tick      <= '0;
      bits_left <= '0;
      shreg     <= '0;
      line      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (bus.valid) begin
            shreg  <= bus.data;
            line   <= 1'b0;
            busy_q <= 1'b1;
            tick   <= TICK_LOAD;
            state  <= TX_START;
          end
        end
        TX_START: begin
          if (tick == '0) begin
            line      <= shreg[0];
            shreg     <= {1'b0, shreg[NUM_BITS-1:1]};
            bits_left <= LAST_BIT;
            tick      <= TICK_LOAD;
            state     <= TX_DATA;
          end else begin
            tick <= tick - 1'b1;
          end
        end
        TX_DATA: begin
          if (tick == '0) begin
            tick <= TICK_LOAD;
            if (bits_left == '0) begin
              line  <= 1'b1;
              state <= TX_STOP;
            end else begin
              line      <= shreg[0];
              shreg     <= {1'b0, shreg[NUM_BITS-1:1]};
              bits_left <= bits_left - 1'b1;
            end
          end else begin
            tick <= tick - 1'b1;
          end
        end
        TX_STOP: begin
          // Returning to idle guarantees at least one non-busy cycle between frames.
          if (tick == '0) begin
            busy_q <= 1'b0;
            state  <= TX_IDLE;
          end else begin
            tick <= tick - 1'b1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tt_um_uart.sv
// Tiny Tapeout pin wrapper around independent UART transmit and receive paths.
// rst_n is active-high despite its name; the name follows the template pinout.
module tt_um_uart
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena
);

  uart_if tx_bus ();
  uart_if rx_bus ();

  logic tx_line;

  wire unused_pins = &{ena, uio_in[7:2], 1'b0};

  assign tx_bus.data  = ui_in[NUM_BITS-1:0];
  assign tx_bus.valid = uio_in[1];
  assign tx_bus.err   = 1'b0;
  assign rx_bus.busy  = 1'b0;

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk  (clk),
    .rst  (rst_n),
    .bus  (tx_bus.slave),
    .line (tx_line)
  );

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk  (clk),
    .rst  (rst_n),
    .line (uio_in[0]),
    .bus  (rx_bus.master)
  );

  assign uo_out  = rx_bus.data;
  assign uio_out = {2'b00, rx_bus.err, rx_bus.valid, tx_bus.busy, tx_line, 2'b00};
  assign uio_oe  = 8'b0011_1100;

endmodule

// File: tb/tb_tt_um_uart.sv
// Directed bench for tt_um_uart: reset, TX waveform, RX good/bad/glitch frames, loopback, mid-frame reset.
module tb_tt_um_uart;

  localparam int CPB = 87;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  uart_if host ();

  assign ui_in     = host.data;
  assign uio_in    = {6'b0, host.valid, (loop_en ? uio_out[2] : rx_drv)};
  assign host.busy = uio_out[3];
  assign host.err  = uio_out[5];

  tt_um_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Pulse monitor: counts high cycles and rising edges of rx_valid / rx_frame_err.
  int         v_hi = 0, v_rise = 0, e_hi = 0, e_rise = 0;
  logic       v_prev = 1'b0, e_prev = 1'b0;
  logic [7:0] rx_log[$];

  always @(negedge clk) begin
    v_prev <= uio_out[4];
    e_prev <= uio_out[5];
    if (uio_out[4]) begin
      v_hi <= v_hi + 1;
      if (!v_prev) v_rise <= v_rise + 1;
      rx_log.push_back(uo_out);
    end
    if (uio_out[5]) begin
      e_hi <= e_hi + 1;
      if (!e_prev) e_rise <= e_rise + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx_drv = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      idle(CPB);
    end
    rx_drv = stop_bit;
    idle(CPB);
    rx_drv = 1'b1;
  endtask

  task automatic wait_busy(input logic val, output int cyc);
    cyc = 0;
    while (uio_out[3] !== val && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("busy_wait", {31'b0, uio_out[3]}, {31'b0, val});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         vb, eb, hb, ehb, qb, c, errs;
    logic [9:0] fr;
    logic       exp_line, exp_busy;
    logic [7:0] lb_exp [3];

    host.data  = 8'h00;
    host.valid = 1'b0;

    // Reset held for two edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_uo_out", uo_out, 8'h00);
    chk("rst_uio_out", uio_out, 8'h04);
    chk("rst_uio_oe", uio_oe, 8'h3C);
    rst_n = 1'b0;
    idle(5);

    // TX 0xA5 with a stray start/data change mid-frame
    fr = {1'b1, 8'hA5, 1'b0};
    errs = 0;
    host.data  = 8'hA5;
    host.valid = 1'b1;
    @(negedge clk);
    host.valid = 1'b0;
    host.data  = 8'h00;
    for (int n = 0; n <= 10 * CPB; n++) begin
      exp_line = (n < 10 * CPB) ? fr[n / CPB] : 1'b1;
      exp_busy = (n < 10 * CPB);
      if (uio_out[2] !== exp_line || uio_out[3] !== exp_busy) errs++;
      if (n == 300) begin
        host.valid = 1'b1;
        host.data  = 8'hFF;
      end
      if (n == 301) host.valid = 1'b0;
      if (n < 10 * CPB) @(negedge clk);
    end
    chk("tx_frame_bad_cycles", errs, 0);
    idle(2);
    chk("tx_idle_after", {30'b0, uio_out[3:2]}, 32'h1);

    // RX good frame 0x3C
    vb = v_rise; eb = e_rise; hb = v_hi; qb = rx_log.size();
    send_frame(8'h3C, 1'b1);
    idle(20);
    chk("rx_valid_cnt", v_rise - vb, 1);
    chk("rx_valid_width", v_hi - hb, 1);
    chk("rx_err_cnt", e_rise - eb, 0);
    chk("rx_data", uo_out, 8'h3C);
    chk("rx_log_byte", rx_log[qb], 8'h3C);

    // RX framing error on 0x55
    vb = v_rise; eb = e_rise; ehb = e_hi;
    send_frame(8'h55, 1'b0);
    idle(100);
    chk("ferr_err_cnt", e_rise - eb, 1);
    chk("ferr_err_width", e_hi - ehb, 1);
    chk("ferr_valid_cnt", v_rise - vb, 0);
    chk("ferr_data_kept", uo_out, 8'h3C);

    // 10-cycle glitch, then a real frame proves RX returned to idle
    vb = v_rise; eb = e_rise;
    rx_drv = 1'b0;
    idle(10);
    rx_drv = 1'b1;
    idle(200);
    chk("glitch_valid_cnt", v_rise - vb, 0);
    chk("glitch_err_cnt", e_rise - eb, 0);
    chk("glitch_data_kept", uo_out, 8'h3C);
    vb = v_rise;
    send_frame(8'h5A, 1'b1);
    idle(20);
    chk("post_glitch_valid", v_rise - vb, 1);
    chk("post_glitch_data", uo_out, 8'h5A);

    // Loopback, back-to-back frames with tx_start held high
    lb_exp[0] = 8'h00; lb_exp[1] = 8'hFF; lb_exp[2] = 8'h81;
    qb = rx_log.size(); eb = e_rise;
    loop_en = 1'b1;
    idle(5);
    host.data  = lb_exp[0];
    host.valid = 1'b1;
    wait_busy(1'b1, c);
    chk("lb_start_latency", c, 1);
    host.data = lb_exp[1];
    wait_busy(1'b0, c);
    wait_busy(1'b1, c);
    chk("lb_gap1", c, 1);
    host.data = lb_exp[2];
    wait_busy(1'b0, c);
    wait_busy(1'b1, c);
    chk("lb_gap2", c, 1);
    host.valid = 1'b0;
    wait_busy(1'b0, c);
    idle(100);
    chk("lb_count", rx_log.size() - qb, 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("lb_byte%0d", i), rx_log[qb + i], lb_exp[i]);
    chk("lb_err_cnt", e_rise - eb, 0);
    chk("lb_uo_out", uo_out, 8'h81);

    // Reset in the middle of a looped-back frame
    vb = v_rise; eb = e_rise;
    host.data  = 8'hF0;
    host.valid = 1'b1;
    idle(1);
    host.valid = 1'b0;
    idle(500);
    rst_n = 1'b1;
    idle(2);
    rst_n = 1'b0;
    chk("midrst_uio_out", uio_out, 8'h04);
    chk("midrst_uo_out", uo_out, 8'h00);
    idle(1200);
    chk("midrst_valid_cnt", v_rise - vb, 0);
    chk("midrst_err_cnt", e_rise - eb, 0);
    chk("midrst_idle", uio_out, 8'h04);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tt_um_uart.md
TT_UM_UART -- requirements
Module: tt_um_uart

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, clock cycles per serial bit (10 MHz / 115200 baud); legal range 4..4095.
REQ-002 SHALL have port clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: one clock; reset is synchronous and active-high; port name kept per the Tiny Tapeout template.
REQ-004 SHALL have port ui_in, input, 8 bits: transmit data byte.
REQ-005 SHALL have port uo_out, output, 8 bits: last correctly received byte.
REQ-006 SHALL have port uio_in, input, 8 bits: [0] rx serial line, [1] tx_start; other bits ignored.
REQ-007 SHALL have port uio_out, output, 8 bits: [2] tx serial line, [3] tx_busy, [4] rx_valid, [5] rx_frame_err; other bits 0.
REQ-008 SHALL have port uio_oe, output, 8 bits: constant 8'b0011_1100.
REQ-009 SHALL have port ena, input, 1 bit: ignored, with no functional effect.

Function
REQ-010 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, 1 stop bit 1; each bit exactly CLKS_PER_BIT cycles.
REQ-011 TX FSM SHALL have states IDLE, START, DATA, STOP; tx line 1 in IDLE.
REQ-012 In IDLE with tx_start=1, TX SHALL latch ui_in and enter START next cycle; tx_busy=1 from that cycle until STOP completes.
REQ-013 tx_start and ui_in changes while tx_busy=1 SHALL be ignored; the latched byte stays stable for the frame.
REQ-014 After STOP, TX SHALL return to IDLE for at least one cycle (tx_busy=0); if tx_start still 1, the next frame starts after that cycle.
REQ-015 RX input SHALL pass through a 2-flop synchronizer before use.
REQ-016 RX FSM SHALL have states IDLE, START, DATA, STOP; in IDLE, a synchronized 0 starts START.
REQ-017 In START, RX SHALL sample at CLKS_PER_BIT/2 (integer division); if the sample is 1, treat it as a glitch and return to IDLE with no flags set.
REQ-018 Data bits SHALL be sampled at bit centers, each CLKS_PER_BIT cycles after the previous sample, shifted in LSB first.
REQ-019 Stop sample 1: uo_out SHALL update to the byte and rx_valid SHALL pulse high for exactly 1 cycle.
REQ-020 Stop sample 0: uo_out SHALL be unchanged and rx_frame_err SHALL pulse high for exactly 1 cycle.
REQ-021 After the stop sample, RX SHALL return to IDLE and SHALL wait for the line to go 1 before detecting a new start.
REQ-022 TX and RX SHALL be fully independent; simultaneous operation, including external loopback of uio_out[2] to uio_in[0], SHALL work.
REQ-023 Bit and tick counters SHALL be sized from CLKS_PER_BIT and SHALL not wrap within a bit.

Reset
REQ-024 With rst_n=1 at a clock edge: both FSMs to IDLE; tx line 1; tx_busy, rx_valid, rx_frame_err 0; uo_out 8'h00; synchronizer flops 1.
REQ-025 Reset mid-frame SHALL abort the frame immediately; no partial rx_valid or rx_frame_err pulse.

Structure
REQ-026 Package uart_pkg SHALL hold the FSM state enums (tx_state_t, rx_state_t) and the bit-count constant (8).
REQ-027 The top SHALL instantiate sub-modules uart_tx and uart_rx, each parameterized by CLKS_PER_BIT; the top contains only pin mapping.

Verification
REQ-028 Reset: assert rst_n=1 for 2 cycles -> uo_out=0x00, uio_out=0x04, uio_oe=0x3C.
REQ-029 TX: ui_in=0xA5, tx_start 1-cycle pulse -> line shows 0,1,0,1,0,0,1,0,1,1, each 87 cycles; tx_busy=1 for 870 cycles.
REQ-030 RX: drive frame for 0x3C at 87 cycles/bit -> rx_valid 1-cycle pulse, then uo_out=0x3C.
REQ-031 Framing error: drive 0x55 with stop bit 0 -> rx_frame_err 1-cycle pulse, uo_out keeps its prior value, no rx_valid.
REQ-032 Glitch: 10-cycle low pulse on rx -> no rx_valid, no rx_frame_err, RX back in IDLE.
REQ-033 Loopback: connect tx to rx, send 0x00, 0xFF, 0x81 back-to-back with tx_start held 1 -> uo_out sequence 0x00, 0xFF, 0x81.
